// File: rtl/qd_pkg.sv
// Shared types and helpers for the quadrature decoder: phase FSM encoding,
// Gray phase constants and the step classifier.
package qd_pkg;

    // Phase states carry the accepted {A,B} in bits [1:0]; bit 2 marks INIT.
    typedef enum logic [2:0] {
        ST_P00  = 3'b000,
        ST_P01  = 3'b001,
        ST_P11  = 3'b011,
        ST_P10  = 3'b010,
        ST_INIT = 3'b100
    } qd_state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef struct packed {
        logic fwd;
        logic rev;
        logic illegal;
    } qd_step_t;

    // Classify a move between two Gray phases.
    // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic qd_step_t step_dir(input logic [1:0] prev, input logic [1:0] next);
        qd_step_t s;
        s         = '0;
        s.illegal = ((prev ^ next) == 2'b11);
        case ({prev, next})
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: s.fwd = 1'b1;
            {PH_01, PH_00}, {PH_11, PH_01}, {PH_10, PH_11}, {PH_00, PH_10}: s.rev = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    function automatic qd_state_t phase_state(input logic [1:0] ph);
        return qd_state_t'({1'b0, ph});
    endfunction

endpackage

// File: rtl/qd_sync_filter.sv
// Synchronizer plus stability filter on the 2-bit {A,B} bus. Both phases
// travel together so a simultaneous two-bit change stays visible as one event.
module qd_sync_filter
    import qd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 2
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [1:0] din,
    output logic [1:0] acc,
    output logic       changed
);
    localparam int RW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0][1:0] sync;
    logic [SYNC_STAGES-1:0]      vld_pipe;
    logic [1:0]                  samp;
    logic                        svld;
    logic [1:0]                  prev;
    logic [RW-1:0]               run;
    logic [RW:0]                 cur;
    logic                        acc_vld;

    assign samp = sync[SYNC_STAGES-1];
    assign svld = vld_pipe[SYNC_STAGES-1];

    // Synchronizer chain; vld_pipe marks when the last stage holds a real pin sample
    // rather than a reset value.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync     <= '0;
            vld_pipe <= '0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], din};
            vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Length of the run of identical samples ending with the current one.
    always_comb begin
        cur = (RW+1)'(1);
        if (run != '0 && samp == prev) cur = {1'b0, run} + 1'b1;
    end

    // Accept a value once it has been stable FILT_LEN samples; the very first
    // stable value after reset is always accepted so the FSM can leave INIT.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            prev    <= '0;
            run     <= '0;
            acc     <= '0;
            acc_vld <= 1'b0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (!svld) begin
                run <= '0;
            end else begin
                prev <= samp;
                run  <= (cur > (RW+1)'(FILT_LEN)) ? RW'(FILT_LEN) : cur[RW-1:0];
                if (cur >= (RW+1)'(FILT_LEN) && (!acc_vld || samp != acc)) begin
                    acc     <= samp;
                    acc_vld <= 1'b1;
                    changed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered {A,B} phases drive a Gray-phase FSM that
// produces step pulses and a wrap-around up/down position counter.
module quad_decoder
    import qd_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 2
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             A,
    input  logic             B,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Count,
    output logic             up_pulse,
    output logic             dn_pulse,
    output logic             UpOrDown,
    output logic             err,
    output logic             err_sticky
);
    qd_state_t  state;
    logic [1:0] ph;
    logic       ph_chg;
    logic       live;
    qd_step_t   st;

    qd_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_filt (
        .Clk    (Clk),
        .reset_n(reset_n),
        .din    ({A, B}),
        .acc    (ph),
        .changed(ph_chg)
    );

    // A phase change only counts once the FSM knows where it started from.
    assign live = ph_chg && (state != ST_INIT);
    assign st   = step_dir(state[1:0], ph);

    // Phase FSM with registered pulses, direction, sticky error and counter.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            Count      <= '0;
            up_pulse   <= 1'b0;
            dn_pulse   <= 1'b0;
            UpOrDown   <= 1'b1;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            up_pulse <= live && st.fwd;
            dn_pulse <= live && st.rev;
            err      <= live && st.illegal;

            // Illegal jumps still move the FSM so it resynchronizes to the pins.
            if (ph_chg) state <= phase_state(ph);

            if (live && st.fwd) UpOrDown <= 1'b1;
            else if (live && st.rev) UpOrDown <= 1'b0;

            // load overrides a coincident step in the count only.
            if (load) Count <= load_val;
            else if (live && st.fwd) Count <= Count + WIDTH'(1);
            else if (live && st.rev) Count <= Count - WIDTH'(1);

            if (live && st.illegal) err_sticky <= 1'b1;
            else if (clr_err) err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized self-checking bench for quad_decoder against a phase-index model.
module tb_quad_decoder;
    localparam int EFF = 5;  // first posedge after a pin change is 1; result lands on edge 5

    logic       Clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       A = 1'b0, B = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       clr_err = 1'b0;
    logic [3:0] Count;
    logic       up_pulse, dn_pulse, UpOrDown, err, err_sticky;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int         m_cnt;
    bit         m_dir, m_sticky;
    logic [1:0] m_phase;
    bit         e_up, e_dn, e_err;
    logic [1:0] gray [4];

    quad_decoder #(.WIDTH(4), .SYNC_STAGES(2), .FILT_LEN(2)) dut (
        .Clk(Clk), .reset_n(reset_n), .A(A), .B(B), .load(load), .load_val(load_val),
        .clr_err(clr_err), .Count(Count), .up_pulse(up_pulse), .dn_pulse(dn_pulse),
        .UpOrDown(UpOrDown), .err(err), .err_sticky(err_sticky)
    );

    always #5 Clk = ~Clk;

    // Position of a phase in the forward rotation.
    function automatic int gidx(input logic [1:0] p);
        for (int i = 0; i < 4; i++) if (gray[i] == p) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(Count), 32'(m_cnt));
        chk({tag, ".up"}, 32'(up_pulse), 32'(e_up));
        chk({tag, ".dn"}, 32'(dn_pulse), 32'(e_dn));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
        chk({tag, ".dir"}, 32'(UpOrDown), 32'(m_dir));
    endtask

    // Drive a new phase, hold 8 cycles, optionally load/clear on the result cycle.
    task automatic step(input string tag, input logic [1:0] ab, input bit ld,
                        input logic [3:0] ldv, input bit clr);
        int d;
        {A, B} = ab;
        d = (gidx(ab) - gidx(m_phase) + 4) % 4;
        for (int c = 1; c <= 8; c++) begin
            @(posedge Clk); #1;
            e_up = 0; e_dn = 0; e_err = 0;
            if (c == EFF) begin
                if (d == 1) begin e_up = 1; m_dir = 1; m_cnt = (m_cnt + 1) % 16; end
                else if (d == 3) begin e_dn = 1; m_dir = 0; m_cnt = (m_cnt + 15) % 16; end
                else if (d == 2) e_err = 1;
                m_phase = ab;
                if (ld) m_cnt = int'(ldv);
                if (e_err) m_sticky = 1;
                else if (clr) m_sticky = 0;
            end
            chk_all(tag);
            if (c == EFF - 1) begin load = ld; load_val = ldv; clr_err = clr; end
            if (c == EFF) begin load = 0; clr_err = 0; end
        end
    endtask

    task automatic fwd(input string tag);
        step(tag, gray[(gidx(m_phase) + 1) % 4], 0, 4'd0, 0);
    endtask

    task automatic rev(input string tag);
        step(tag, gray[(gidx(m_phase) + 3) % 4], 0, 4'd0, 0);
    endtask

    // One-cycle pulse on A must be ignored entirely.
    task automatic glitch(input string tag);
        A = ~A;
        @(posedge Clk); #1;
        A = ~A;
        e_up = 0; e_dn = 0; e_err = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk); #1;
            chk_all(tag);
        end
    endtask

    // Async reset mid-cycle, then the first accepted phase only seeds the FSM.
    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        m_cnt = 0; m_dir = 1; m_sticky = 0;
        e_up = 0; e_dn = 0; e_err = 0;
        chk_all({tag, ".async"});
        repeat (2) @(posedge Clk);
        #2 reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk); #1;
            chk_all({tag, ".init"});
        end
        m_phase = {A, B};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
        m_phase = 2'b00;

        // Reset with pins idle at 00
        do_reset("t1");

        // 16 forward steps with wrap to 0
        for (int i = 0; i < 16; i++) fwd("t2_fwd");

        // 3 reverse steps: 15, 14, 13
        for (int i = 0; i < 3; i++) rev("t3_rev");

        // Phase 01 then an illegal jump to 10, clear, then a normal forward step
        step("t4_to01", 2'b01, 0, 4'd0, 0);
        step("t4_jump", 2'b10, 0, 4'd0, 0);
        step("t4_clr", 2'b10, 0, 4'd0, 1);
        fwd("t4_fwd");

        // Glitch, then a load coincident with a forward step
        glitch("t5_glitch");
        step("t5_load", gray[(gidx(m_phase) + 1) % 4], 1, 4'd9, 0);

        // Walk down to 7, start a step, and reset before it completes
        rev("t6_rev");
        rev("t6_rev");
        chk("t6_pre_count", 32'(Count), 32'd7);
        {A, B} = gray[(gidx(m_phase) + 1) % 4];
        @(posedge Clk); #1;
        do_reset("t6");
        fwd("t6_after");

        // Random mix of steps, jumps, glitches, loads and clears
        for (int i = 0; i < 60; i++) begin
            int r;
            bit clr;
            r   = int'($urandom_range(0, 5));
            clr = ($urandom_range(0, 3) == 0);
            case (r)
                0, 1: step("rnd_fwd", gray[(gidx(m_phase) + 1) % 4], 0, 4'd0, clr);
                2:    step("rnd_rev", gray[(gidx(m_phase) + 3) % 4], 0, 4'd0, clr);
                3:    step("rnd_bad", m_phase ^ 2'b11, 0, 4'd0, clr);
                4:    glitch("rnd_glitch");
                default: step("rnd_load", gray[(gidx(m_phase) + $urandom_range(0, 3)) % 4],
                              1, 4'($urandom_range(0, 15)), clr);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
